// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Load/store port between the CPU (master) and the data-memory
//   responder (slave).
//   req_valid/req_ready : request handshake, accepted when both high at a clock edge
//   req_wr              : 1 = store (sw), 0 = load (lw)
//   req_addr            : byte address (ALU result)
//   req_wdata           : store data (busB)
//   rsp_valid           : one-cycle completion pulse for loads and stores
//   rsp_rdata           : load data, qualified by rsp_valid
//   rsp_err             : access fault (misaligned / out of range), qualified by rsp_valid
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-addressed data memory answering CPU lw/sw requests after WAIT_CYC
//   wait states. Misaligned or out-of-range accesses complete with rsp_err=1,
//   rsp_rdata=0 and no write.
//   Optional macro DMEM_CLEAR_ON_RESET_EN: reset sweeps the whole memory to
//   zero (one word per cycle) before accepting requests.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dmem_responder_if.slave (request/response handshake)
// Parameters
//   ADDR_W    : word-index bits, depth = 2**ADDR_W 32-bit words
//   WAIT_CYC  : wait states between accept and response (>= 0)
//   BASE_ADDR : byte address of word 0
module dmem_responder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned WAIT_CYC  = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
`ifdef DMEM_CLEAR_ON_RESET_EN
      , S_CLEAR
`endif
   } state_t;

`ifdef DMEM_CLEAR_ON_RESET_EN
   localparam state_t RESET_STATE = S_CLEAR;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               accept, enter_resp;

   logic               lat_wr;
   logic [31:0]        lat_addr, lat_wdata;
   logic [31:0]        rdata_q;
   logic               err_q;

   logic               op_wr;
   logic [31:0]        op_addr, op_wdata, op_off;
   logic               op_fault;
   logic [ADDR_W-1:0]  op_idx;

   logic [31:0]        mem [DEPTH];

`ifdef DMEM_CLEAR_ON_RESET_EN
   logic [ADDR_W-1:0]  clr_idx;
   logic               clr_we;
`endif

   // With WAIT_CYC=0 the edge that accepts is also the edge entering RESP,
   // so the operation must come straight from the bus while in IDLE.
   always_comb begin
      op_wr    = (state == S_IDLE) ? bus.req_wr    : lat_wr;
      op_addr  = (state == S_IDLE) ? bus.req_addr  : lat_addr;
      op_wdata = (state == S_IDLE) ? bus.req_wdata : lat_wdata;
      op_off   = op_addr - BASE_ADDR;
      // Out of range when any offset bit above the word index is set.
      op_fault = (op_off[1:0] != 2'b00) || ((op_off >> (ADDR_W + 2)) != '0);
      op_idx   = op_off[ADDR_W+1:2];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RESET_STATE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      accept        = 1'b0;
      enter_resp    = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_we        = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept = 1'b1;
               if (WAIT_CYC == 0) begin
                  state_nxt  = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_W'(WAIT_CYC);
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               state_nxt  = S_RESP;
               enter_resp = 1'b1;
               cnt_nxt    = '0;
            end
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            state_nxt     = S_IDLE;
         end
`ifdef DMEM_CLEAR_ON_RESET_EN
         S_CLEAR: begin
            clr_we = 1'b1;
            if (clr_idx == '1) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
         clr_idx   <= '0;
`endif
      end else begin
         cnt <= cnt_nxt;
         if (accept) begin
            lat_wr    <= bus.req_wr;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
         end
         if (enter_resp) begin
            err_q   <= op_fault;
            rdata_q <= (op_fault || op_wr) ? '0 : mem[op_idx];
         end
`ifdef DMEM_CLEAR_ON_RESET_EN
         if (clr_we) clr_idx <= clr_idx + 1'b1;
`endif
      end
   end

   // Memory is never reset; reset only suppresses a pending store.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (enter_resp && op_wr && !op_fault) mem[op_idx] <= op_wdata;
`ifdef DMEM_CLEAR_ON_RESET_EN
         if (clr_we) mem[clr_idx] <= '0;
`endif
      end
   end

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule
